enemy_fire_scheduler: RTL and testbench
=======================================

# enemy_fire_scheduler

Decides which living enemy fires next and which free enemy-bullet slot receives the shot. It paces shots on the game tick, shares firing round-robin among alive enemies, and allocates slots from the enemy-bullet pool. It sits beside the game FSM and drives the enemy-bullet spawn path through a valid/ack handshake.

## Interface
- N_ENEMY, 15: enemy count; enemy index = row*5 + column.
- N_SLOT, 31: enemy-bullet slot count.
- FIRE_PERIOD, 8: game ticks between shots; legal range 1..255.
- LFSR_SEED, 16'hACE1: reset value of the jitter LFSR; must be non-zero.
- i_Clock  in  1  system clock; all state updates on the rising edge.
- i_Reset  in  1  reset, asynchronous, active-low.
- i_Tick  in  1  game-tick strobe, one i_Clock cycle wide.
- i_Enable  in  1  high while the game state is PLAYING.
- i_EnemyAlive  in  N_ENEMY  per-enemy alive mask.
- i_SlotBusy  in  N_SLOT  per-slot occupied mask.
- o_FireValid  out  1  shot request pending.
- o_FireEnemy  out  4  index of the shooting enemy; valid while o_FireValid is high.
- o_FireSlot  out  5  slot to fill; valid while o_FireValid is high.
- i_FireAck  in  1  consumer accepted the shot.
- o_Stall  out  1  a shooter is chosen but every slot is busy.

## Operation
- FSM states: IDLE, WAIT, SELECT, ISSUE.
- IDLE
  - Outputs low; counter = FIRE_PERIOD; round-robin pointer rr = 0.
  - Go to WAIT when i_Enable = 1.
- WAIT
  - On each i_Tick, decrement the counter.
  - Tick with counter == 1 → counter 0, go to SELECT.
- SELECT
  - Shooter = first alive enemy scanning rr, rr+1, … N_ENEMY-1, 0 … rr-1 (wraps).
  - Slot = lowest-index clear bit of i_SlotBusy.
  - No alive enemy → reload the counter and return to WAIT; no shot, o_Stall = 0.
  - Alive enemy but no free slot → o_Stall = 1; stay in SELECT and re-evaluate every clock.
  - Both found → register o_FireEnemy and o_FireSlot, go to ISSUE.
- ISSUE
  - o_FireValid = 1. o_FireEnemy and o_FireSlot are held stable until the acknowledge.
  - On i_FireAck: rr = (o_FireEnemy + 1) mod N_ENEMY; reload the counter; go to WAIT.
  - i_EnemyAlive and i_SlotBusy changes during ISSUE are ignored.
- i_Enable low in any state → IDLE on the next clock. o_FireValid drops on that clock; a pending shot is discarded.
- i_Tick pulses outside WAIT are ignored; no tick accumulation.
- Counter is 9 bits, so the jitter maximum of 258 fits. Reload value is FIRE_PERIOD, or the jittered value described under Configuration.
- Index arithmetic is modulo N_ENEMY; it never yields a value ≥ N_ENEMY.

## Timing
- Reset values:
  - o_FireValid = 0, o_FireEnemy = 0, o_FireSlot = 0, o_Stall = 0.
  - State IDLE, rr = 0, counter = FIRE_PERIOD, LFSR = LFSR_SEED.
- All outputs are registered.
- Enable rises at clock k → WAIT at k+1.
- The FIRE_PERIOD-th tick seen in WAIT → SELECT on the next clock. o_FireValid rises one clock later if a slot is free.
- Handshake:
  - Transfer occurs on a clock where o_FireValid and i_FireAck are both high.
  - o_FireValid is low on the following clock; no back-to-back shots.
  - i_FireAck while o_FireValid is low is ignored.
- Stall: o_Stall rises one clock after SELECT is entered with all slots busy. It falls on the clock the FSM leaves SELECT.
- Asynchronous reset mid-ISSUE: o_FireValid clears immediately, without waiting for a clock edge.

## Configuration
- ENEMY_FIRE_JITTER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances on every i_Tick in every state.
  - Reload value = FIRE_PERIOD + LFSR[1:0], giving an interval of FIRE_PERIOD to FIRE_PERIOD+3 ticks.
- ENEMY_FIRE_JITTER_EN undefined:
  - No LFSR is built.
  - Reload value = FIRE_PERIOD exactly.

## Test plan
- Reset, enable, all 15 enemies alive, all slots free, FIRE_PERIOD=8, ack one clock after valid → shooters 0,1,2,… in order, slots 0 each time, exactly 8 ticks apart.
- Enemies 0–4 dead, rr=0 → first shooter 5; after acking 14, next shooter is 5 (wrap).
- i_SlotBusy all ones at SELECT → o_Stall=1, o_FireValid=0; clear bit 7 → o_FireSlot=7 with o_FireValid one clock later, o_Stall=0.
- i_EnemyAlive=0 at SELECT → no valid, counter reloaded, next SELECT 8 ticks later.
- Valid pending, i_FireAck held low for 20 clocks while i_SlotBusy and i_EnemyAlive toggle → outputs stable; ack → valid low next clock; drop i_Enable mid-ISSUE → IDLE, valid low, rr=0.
- With ENEMY_FIRE_JITTER_EN, 200 shots → every interval in 8..11 ticks, sequence reproducible from LFSR_SEED; without the macro, all intervals are 8.

Source files
------------

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
//
// Paces enemy shots on the game tick, picks the next living enemy in
// round-robin order, and allocates the lowest free enemy-bullet slot.
// The chosen shot is offered to the bullet spawn path via valid/ack.
//
// Optional feature: define ENEMY_FIRE_JITTER_EN to build a 16-bit LFSR
// that randomises the shot interval to FIRE_PERIOD..FIRE_PERIOD+3 ticks.
// Without the macro the interval is exactly FIRE_PERIOD ticks.
//
// Ports:
//   i_Clock       system clock, rising edge
//   i_Reset       asynchronous reset, active low
//   i_Tick        one-cycle game-tick strobe
//   i_Enable      high while the game is in PLAYING
//   i_EnemyAlive  per-enemy alive mask (index = row*5 + column)
//   i_SlotBusy    per-slot occupied mask of the enemy-bullet pool
//   o_FireValid   shot request pending
//   o_FireEnemy   shooting enemy index, valid with o_FireValid
//   o_FireSlot    bullet slot to fill, valid with o_FireValid
//   i_FireAck     consumer accepted the shot
//   o_Stall       a shooter is chosen but every slot is busy

module enemy_fire_scheduler #(
    parameter int          N_ENEMY     = 15,
    parameter int          N_SLOT      = 31,
    parameter int          FIRE_PERIOD = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic               i_Tick,
    input  logic               i_Enable,
    input  logic [N_ENEMY-1:0] i_EnemyAlive,
    input  logic [N_SLOT-1:0]  i_SlotBusy,
    output logic               o_FireValid,
    output logic [3:0]         o_FireEnemy,
    output logic [4:0]         o_FireSlot,
    input  logic               i_FireAck,
    output logic               o_Stall
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SELECT = 2'd2;
    localparam logic [1:0] S_ISSUE  = 2'd3;

    // Counter is 9 bits so FIRE_PERIOD (max 255) plus jitter (max 3) fits.
    localparam logic [8:0] PERIOD_9 = 9'(FIRE_PERIOD);

    logic [1:0] state;
    logic [8:0] counter;
    logic [3:0] rrPtr;
    logic [8:0] reloadValue;

    logic       shooterFound;
    logic [3:0] shooterIdx;
    logic [4:0] candidate;
    logic       slotFound;
    logic [4:0] slotIdx;

`ifdef ENEMY_FIRE_JITTER_EN
    // Fibonacci LFSR, taps 16,14,13,11; advances on every tick regardless
    // of FSM state so the jitter sequence depends only on tick history.
    logic [15:0] lfsr;
    logic        lfsrFeedback;

    assign lfsrFeedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            lfsr <= LFSR_SEED;
        end else if (i_Tick) begin
            lfsr <= {lfsr[14:0], lfsrFeedback};
        end
    end

    assign reloadValue = PERIOD_9 + {7'd0, lfsr[1:0]};
`else
    assign reloadValue = PERIOD_9;
`endif

    // Round-robin shooter search: first alive enemy at rr, rr+1, ... with
    // wrap. rrPtr is always < N_ENEMY, so one conditional subtract keeps
    // the candidate in range.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        shooterFound = 1'b0;
        shooterIdx   = '0;
        candidate    = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            candidate = {1'b0, rrPtr} + 5'(i);
            if (candidate >= 5'(N_ENEMY)) begin
                candidate = candidate - 5'(N_ENEMY);
            end
            if (!shooterFound && i_EnemyAlive[candidate[3:0]]) begin
                shooterFound = 1'b1;
                shooterIdx   = candidate[3:0];
            end
        end
    end

    // Lowest-index free slot.
    always_comb begin
        slotFound = 1'b0;
        slotIdx   = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            if (!slotFound && !i_SlotBusy[i]) begin
                slotFound = 1'b1;
                slotIdx   = 5'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state       <= S_IDLE;
            counter     <= PERIOD_9;
            rrPtr       <= '0;
            o_FireValid <= 1'b0;
            o_FireEnemy <= '0;
            o_FireSlot  <= '0;
            o_Stall     <= 1'b0;
        end else if (!i_Enable) begin
            // Leaving PLAYING discards any pending shot and restarts pacing.
            state       <= S_IDLE;
            counter     <= PERIOD_9;
            rrPtr       <= '0;
            o_FireValid <= 1'b0;
            o_FireEnemy <= '0;
            o_FireSlot  <= '0;
            o_Stall     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (i_Tick) begin
                        if (counter == 9'd1) begin
                            counter <= '0;
                            state   <= S_SELECT;
                        end else begin
                            counter <= counter - 9'd1;
                        end
                    end
                end

                S_SELECT: begin
                    if (!shooterFound) begin
                        // Nobody left to shoot: skip this period.
                        counter <= reloadValue;
                        o_Stall <= 1'b0;
                        state   <= S_WAIT;
                    end else if (!slotFound) begin
                        // Re-evaluated every clock until a slot frees up.
                        o_Stall <= 1'b1;
                    end else begin
                        o_FireEnemy <= shooterIdx;
                        o_FireSlot  <= slotIdx;
                        o_FireValid <= 1'b1;
                        o_Stall     <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Enemy and slot stay frozen until accepted.
                    if (i_FireAck) begin
                        o_FireValid <= 1'b0;
                        rrPtr       <= (o_FireEnemy == 4'(N_ENEMY - 1)) ?
                                       4'd0 : o_FireEnemy + 4'd1;
                        counter     <= reloadValue;
                        state       <= S_WAIT;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// tb_enemy_fire_scheduler
//
// Directed bench for enemy_fire_scheduler. Ticks are issued every fourth
// clock; shot intervals are measured as ticks seen between the accepting
// edge (exclusive) and the edge that raises o_FireValid (inclusive).
// If ENEMY_FIRE_JITTER_EN is defined the interval checks accept the
// jittered range instead of the exact period.

module tb_enemy_fire_scheduler;

    localparam int N_ENEMY = 15;
    localparam int N_SLOT  = 31;

    logic               i_Clock;
    logic               i_Reset;
    logic               i_Tick;
    logic               i_Enable;
    logic [N_ENEMY-1:0] i_EnemyAlive;
    logic [N_SLOT-1:0]  i_SlotBusy;
    logic               o_FireValid;
    logic [3:0]         o_FireEnemy;
    logic [4:0]         o_FireSlot;
    logic               i_FireAck;
    logic               o_Stall;

    int assertCount = 0;
    int failCount   = 0;
    int ticksSeen   = 0;
    int tickBase    = 0;
    int tickPhase   = 0;
    bit tickOn      = 1'b0;
    bit gotValid;

    enemy_fire_scheduler #(
        .N_ENEMY    (N_ENEMY),
        .N_SLOT     (N_SLOT),
        .FIRE_PERIOD(8),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Tick      (i_Tick),
        .i_Enable    (i_Enable),
        .i_EnemyAlive(i_EnemyAlive),
        .i_SlotBusy  (i_SlotBusy),
        .o_FireValid (o_FireValid),
        .o_FireEnemy (o_FireEnemy),
        .o_FireSlot  (o_FireSlot),
        .i_FireAck   (i_FireAck),
        .o_Stall     (o_Stall)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Exact interval normally; jittered range when the feature is built.
    task automatic checkInterval(input string tag, input int got, input int lo, input int hi);
`ifdef ENEMY_FIRE_JITTER_EN
        check(tag, 32'(got >= lo && got <= hi), 32'd1);
`else
        check(tag, 32'(got), 32'(lo));
        if (hi < lo) $display("note: bad interval bounds for %s", tag);
`endif
    endtask

    // One clock: drive tick, wait for the edge, sample 1 ns later.
    task automatic cyc();
        i_Tick = tickOn && (tickPhase == 0);
        tickPhase = (tickPhase + 1) % 4;
        @(posedge i_Clock);
        #1;
        if (i_Tick) ticksSeen++;
    endtask

    task automatic waitValid(input string tag);
        for (int n = 0; n < 400 && !o_FireValid; n++) cyc();
        gotValid = o_FireValid;
        check({tag, "_valid_seen"}, 32'(o_FireValid), 32'd1);
    endtask

    task automatic ackShot(input string tag);
        i_FireAck = 1'b1;
        cyc();
        i_FireAck = 1'b0;
        check({tag, "_valid_low_after_ack"}, 32'(o_FireValid), 32'd0);
        tickBase = ticksSeen;
    endtask

    task automatic dropEnable(input string tag);
        i_Enable = 1'b0;
        tickOn   = 1'b0;
        cyc();
        check({tag, "_valid_low_disabled"}, 32'(o_FireValid), 32'd0);
        check({tag, "_stall_low_disabled"}, 32'(o_Stall), 32'd0);
    endtask

    task automatic startEnable();
        i_Enable = 1'b1;
        cyc();
        tickOn    = 1'b1;
        tickPhase = 0;
        tickBase  = ticksSeen;
    endtask

    task automatic shot(input string tag, input int enemy, input int slot, input int lo, input int hi);
        waitValid(tag);
        check({tag, "_enemy"}, 32'(o_FireEnemy), 32'(enemy));
        check({tag, "_slot"}, 32'(o_FireSlot), 32'(slot));
        checkInterval({tag, "_interval"}, ticksSeen - tickBase, lo, hi);
        check({tag, "_stall"}, 32'(o_Stall), 32'd0);
    endtask

    initial begin
        i_Reset      = 1'b0;
        i_Tick       = 1'b0;
        i_Enable     = 1'b0;
        i_EnemyAlive = '1;
        i_SlotBusy   = '0;
        i_FireAck    = 1'b0;

        // Reset state.
        repeat (3) cyc();
        check("rst_valid", 32'(o_FireValid), 32'd0);
        check("rst_enemy", 32'(o_FireEnemy), 32'd0);
        check("rst_slot", 32'(o_FireSlot), 32'd0);
        check("rst_stall", 32'(o_Stall), 32'd0);
        i_Reset = 1'b1;
        cyc();
        check("idle_valid", 32'(o_FireValid), 32'd0);

        // All alive, all free: shooters 0..3 in order, slot 0, 8 ticks apart.
        startEnable();
        shot("a0", 0, 0, 8, 8);
        ackShot("a0");
        for (int s = 1; s < 4; s++) begin
            shot($sformatf("a%0d", s), s, 0, 8, 11);
            ackShot($sformatf("a%0d", s));
        end

        // Enemies 0-4 dead, rr back to 0: 5..14 then wrap to 5.
        dropEnable("b");
        i_EnemyAlive = 15'h7FE0;
        startEnable();
        shot("b5", 5, 0, 8, 8);
        ackShot("b5");
        for (int s = 6; s < 15; s++) begin
            shot($sformatf("b%0d", s), s, 0, 8, 11);
            ackShot($sformatf("b%0d", s));
        end
        shot("b_wrap", 5, 0, 8, 11);
        ackShot("b_wrap");

        // All slots busy: stall, then free slot 7. rr is 6.
        i_EnemyAlive = '1;
        i_SlotBusy   = '1;
        for (int n = 0; n < 400 && !o_Stall; n++) cyc();
        check("c_stall_rise", 32'(o_Stall), 32'd1);
        checkInterval("c_stall_interval", ticksSeen - tickBase, 8, 11);
        for (int n = 0; n < 3; n++) begin
            cyc();
            check("c_stall_hold", 32'(o_Stall), 32'd1);
            check("c_no_valid", 32'(o_FireValid), 32'd0);
        end
        i_SlotBusy = ~(31'd1 << 7);
        cyc();
        check("c_valid", 32'(o_FireValid), 32'd1);
        check("c_slot7", 32'(o_FireSlot), 32'd7);
        check("c_enemy6", 32'(o_FireEnemy), 32'd6);
        check("c_stall_fall", 32'(o_Stall), 32'd0);
        ackShot("c");
        i_SlotBusy = '0;

        // Nobody alive at SELECT: no shot, reload, next SELECT one period on.
        i_EnemyAlive = '0;
        for (int n = 0; n < 400 && (ticksSeen - tickBase) < 8; n++) cyc();
        cyc();
        cyc();
        check("d_no_valid", 32'(o_FireValid), 32'd0);
        check("d_no_stall", 32'(o_Stall), 32'd0);
        i_EnemyAlive = '1;
        shot("d", 7, 0, 16, 22);
        ackShot("d");

        // Hold ack low while inputs churn; outputs must stay frozen.
        shot("e8", 8, 0, 8, 11);
        for (int n = 0; n < 20; n++) begin
            i_SlotBusy   = n[0] ? '1 : 31'h0000_0055;
            i_EnemyAlive = n[0] ? '0 : 15'h00F0;
            cyc();
            check("e_hold_valid", 32'(o_FireValid), 32'd1);
            check("e_hold_enemy", 32'(o_FireEnemy), 32'd8);
            check("e_hold_slot", 32'(o_FireSlot), 32'd0);
        end
        i_EnemyAlive = '1;
        i_SlotBusy   = '0;
        ackShot("e8");

        // Ack while no shot is pending is ignored.
        i_FireAck = 1'b1;
        cyc();
        i_FireAck = 1'b0;
        check("e_stray_ack", 32'(o_FireValid), 32'd0);
        shot("e9", 9, 0, 8, 11);

        // Drop enable mid-ISSUE: shot discarded, rr restarts at 0.
        dropEnable("f");
        startEnable();
        shot("f0", 0, 0, 8, 8);

        // Asynchronous reset clears valid without a clock edge.
        #2;
        i_Reset = 1'b0;
        #1;
        check("g_async_valid", 32'(o_FireValid), 32'd0);
        check("g_async_enemy", 32'(o_FireEnemy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
